// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: FETCH (req until ack) then EXEC (hold while stall), 2 cycles/instr with zero-wait ack.
// Backpressure: imem wait states hold FETCH; stall holds EXEC with op, pc and retire_cnt frozen.
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter int              OP_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00,
   parameter logic [OP_W-1:0] NOP_OP   = 16'h0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_in,
   input  logic            pc_we,
   input  logic            stall,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [OP_W-1:0] imem_rdata,
   output logic [OP_W-1:0] op,
   output logic            op_valid,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     retire_cnt
);

   typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [15:0]     retire_q, retire_d;
   logic            op_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RESET;
         pc_q       <= RESET_PC;
         op_q       <= NOP_OP;
         retire_q   <= 16'd0;
         op_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         op_q       <= op_d;
         retire_q   <= retire_d;
         op_valid_q <= (state_d == S_EXEC);
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      op_d     = op_q;
      retire_d = retire_q;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               op_d    = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            // stall has priority over a jump; pc_we is looked at again once stall drops
            if (!stall) begin
               pc_d     = pc_we ? pc_in : pc_q + PC_W'(1);
               retire_d = retire_q + 16'd1;
               state_d  = S_FETCH;
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign op         = op_valid_q ? op_q : NOP_OP;
   assign op_valid   = op_valid_q;
   assign pc         = pc_q;
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, hand sequences for wrap/stall/reset corners, then randomized run vs a cycle model.
module tb_fetch_unit;

   logic        clk, rst;
   logic [7:0]  pc_in;
   logic        pc_we, stall;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] op;
   logic        op_valid;
   logic [7:0]  pc;
   logic [15:0] retire_cnt;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_we(pc_we), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .op(op), .op_valid(op_valid), .pc(pc),
      .retire_cnt(retire_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        ack;
      logic [15:0] rdata;
      logic        stl;
      logic        we;
      logic [7:0]  pin;
      logic        e_req;
      logic [7:0]  e_addr;
      logic [15:0] e_op;
      logic        e_vld;
      logic [7:0]  e_pc;
      logic [15:0] e_rc;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(logic ack, logic [15:0] rdata, logic stl, logic we, logic [7:0] pin,
                               logic e_req, logic [7:0] e_addr, logic [15:0] e_op, logic e_vld,
                               logic [7:0] e_pc, logic [15:0] e_rc);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.stl = stl; v.we = we; v.pin = pin;
      v.e_req = e_req; v.e_addr = e_addr; v.e_op = e_op; v.e_vld = e_vld;
      v.e_pc = e_pc; v.e_rc = e_rc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_req, input logic [7:0] e_addr,
                          input logic [15:0] e_op, input logic e_vld, input logic [7:0] e_pc,
                          input logic [15:0] e_rc);
      chk({tag, ".req"},   32'(imem_req),   32'(e_req));
      chk({tag, ".addr"},  32'(imem_addr),  32'(e_addr));
      chk({tag, ".op"},    32'(op),         32'(e_op));
      chk({tag, ".vld"},   32'(op_valid),   32'(e_vld));
      chk({tag, ".pc"},    32'(pc),         32'(e_pc));
      chk({tag, ".rcnt"},  32'(retire_cnt), 32'(e_rc));
   endtask

   task automatic drive(input logic ack, input logic [15:0] rdata, input logic stl,
                        input logic we, input logic [7:0] pin);
      imem_ack = ack; imem_rdata = rdata; stall = stl; pc_we = we; pc_in = pin;
   endtask

   // reference model: position in the fetch/execute cycle plus architectural counters
   int          m_phase;   // 0 idle after reset, 1 waiting for word, 2 instruction live
   logic [7:0]  m_pc;
   logic [15:0] m_op;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_phase = 0; m_pc = 8'h00; m_op = 16'h0000; m_cnt = 16'd0;
   endtask

   task automatic model_step();
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
         if (imem_ack) begin m_op = imem_rdata; m_phase = 2; end
      end else if (!stall) begin
         m_pc  = pc_we ? pc_in : m_pc + 8'd1;
         m_cnt = m_cnt + 16'd1;
         m_phase = 1;
      end
   endtask

   initial begin
      tbl[0]  = mk(0, 16'h0000, 0, 0, 8'h00,  0, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
      tbl[1]  = mk(1, 16'h1000, 0, 0, 8'h00,  1, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
      tbl[2]  = mk(0, 16'h0000, 0, 0, 8'h00,  0, 8'h00, 16'h1000, 1, 8'h00, 16'd0);
      tbl[3]  = mk(1, 16'h1001, 0, 0, 8'h00,  1, 8'h01, 16'h0000, 0, 8'h01, 16'd1);
      tbl[4]  = mk(0, 16'h0000, 0, 0, 8'h00,  0, 8'h01, 16'h1001, 1, 8'h01, 16'd1);
      tbl[5]  = mk(1, 16'h1002, 0, 0, 8'h00,  1, 8'h02, 16'h0000, 0, 8'h02, 16'd2);
      tbl[6]  = mk(0, 16'h0000, 0, 0, 8'h00,  0, 8'h02, 16'h1002, 1, 8'h02, 16'd2);
      tbl[7]  = mk(0, 16'hBEEF, 0, 1, 8'h77,  1, 8'h03, 16'h0000, 0, 8'h03, 16'd3);
      tbl[8]  = mk(0, 16'hBEEF, 0, 0, 8'h00,  1, 8'h03, 16'h0000, 0, 8'h03, 16'd3);
      tbl[9]  = mk(0, 16'hBEEF, 0, 0, 8'h00,  1, 8'h03, 16'h0000, 0, 8'h03, 16'd3);
      tbl[10] = mk(1, 16'h2003, 0, 0, 8'h00,  1, 8'h03, 16'h0000, 0, 8'h03, 16'd3);
      tbl[11] = mk(0, 16'h0000, 0, 1, 8'h05,  0, 8'h03, 16'h2003, 1, 8'h03, 16'd3);
      tbl[12] = mk(1, 16'h3005, 0, 1, 8'h77,  1, 8'h05, 16'h0000, 0, 8'h05, 16'd4);
      tbl[13] = mk(0, 16'h0000, 0, 1, 8'h40,  0, 8'h05, 16'h3005, 1, 8'h05, 16'd4);
      tbl[14] = mk(1, 16'h4040, 0, 0, 8'h00,  1, 8'h40, 16'h0000, 0, 8'h40, 16'd5);
      tbl[15] = mk(1, 16'hDEAD, 1, 1, 8'h10,  0, 8'h40, 16'h4040, 1, 8'h40, 16'd5);
      tbl[16] = mk(0, 16'h0000, 0, 0, 8'h00,  0, 8'h40, 16'h4040, 1, 8'h40, 16'd5);
      tbl[17] = mk(1, 16'h4041, 0, 0, 8'h00,  1, 8'h41, 16'h0000, 0, 8'h41, 16'd6);
      tbl[18] = mk(0, 16'h0000, 0, 1, 8'h41,  0, 8'h41, 16'h4041, 1, 8'h41, 16'd6);
      tbl[19] = mk(0, 16'h0000, 0, 0, 8'h00,  1, 8'h41, 16'h0000, 0, 8'h41, 16'd7);

      rst = 1'b1;
      drive(0, 16'h0000, 0, 0, 8'h00);
      @(posedge clk); #2;
      chk_all("reset", 0, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_op,
                 tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_rc);
         drive(tbl[i].ack, tbl[i].rdata, tbl[i].stl, tbl[i].we, tbl[i].pin);
      end

      // pc wraps FF -> 00 after a 3-cycle stall
      @(negedge clk); chk_all("wrap_f41", 1, 8'h41, 16'h0000, 0, 8'h41, 16'd7);
      drive(1, 16'h5041, 0, 0, 8'h00);
      @(negedge clk); chk_all("wrap_e41", 0, 8'h41, 16'h5041, 1, 8'h41, 16'd7);
      drive(0, 16'h0000, 0, 1, 8'hFF);
      @(negedge clk); chk_all("wrap_fff", 1, 8'hFF, 16'h0000, 0, 8'hFF, 16'd8);
      drive(1, 16'h60FF, 0, 0, 8'h00);
      @(negedge clk); chk_all("wrap_eff", 0, 8'hFF, 16'h60FF, 1, 8'hFF, 16'd8);
      drive(0, 16'h0000, 1, 1, 8'h22);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_all($sformatf("stall%0d", k), 0, 8'hFF, 16'h60FF, 1, 8'hFF, 16'd8);
         drive(1, 16'h9999, (k < 2), 1'b0, 8'h00);
      end
      @(negedge clk); chk_all("wrap_f00", 1, 8'h00, 16'h0000, 0, 8'h00, 16'd9);
      drive(1, 16'h7000, 0, 0, 8'h00);
      @(negedge clk); chk_all("jmp_e00", 0, 8'h00, 16'h7000, 1, 8'h00, 16'd9);
      drive(0, 16'h0000, 0, 1, 8'h33);
      @(negedge clk); chk_all("wait_f33", 1, 8'h33, 16'h0000, 0, 8'h33, 16'd10);
      drive(0, 16'h0000, 0, 0, 8'h00);

      // asynchronous reset during a fetch wait, with a late ack that must be dropped
      @(negedge clk); chk_all("wait2_f33", 1, 8'h33, 16'h0000, 0, 8'h33, 16'd10);
      rst = 1'b1;
      drive(1, 16'hDEAD, 0, 0, 8'h00);
      #1; chk_all("rst_async", 0, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
      @(negedge clk); chk_all("rst_hold", 0, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
      rst = 1'b0;
      @(negedge clk); chk_all("rst_refetch", 1, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
      drive(0, 16'h0000, 0, 0, 8'h00);

      model_reset();
      m_phase = 1;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         if (rst) rst = 1'b0;
         chk_all("rand", (m_phase == 1), m_pc, (m_phase == 2) ? m_op : 16'h0000,
                 (m_phase == 2), m_pc, m_cnt);
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            chk_all("rand_rst", 0, 8'h00, 16'h0000, 0, 8'h00, 16'd0);
         end else begin
            drive(($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0) ? m_pc : 8'($urandom));
            model_step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
